ordered_sets_lane_encoder: RTL

//  Parametrised successor of the single-lane ordered-set encoder: accepts ordered-set requests over a valid/ready handshake.

---
 rtl/aurora_pkg.sv | 76 +++++++
 rtl/idle_char_gen.sv | 60 ++++++
 rtl/ordered_sets_lane_encoder.sv | 112 +++++++++++
 3 files changed

// File: rtl/aurora_pkg.sv
// Aurora TX ordered-set definitions shared by the lane encoder and its idle
// generator.
//   ordered_sets_t : one-hot request code (bit 0 = I ... bit 12 = SNF, 0 = NONE)
//   K*/D*          : unencoded 8b character values
//   ordered_seq_t  : one ordered set, characters in transmit order (slot 0 first)
//   os_lookup()    : maps a request code to its sequence (len 0 for I/unknown)
package aurora_pkg;

  typedef enum logic [12:0] {
    OS_NONE = 13'h0000,
    OS_I    = 13'h0001,
    OS_SP   = 13'h0002,
    OS_SPA  = 13'h0004,
    OS_VER  = 13'h0008,
    OS_SCP  = 13'h0010,
    OS_ECP  = 13'h0020,
    OS_P    = 13'h0040,
    OS_SUF  = 13'h0080,
    OS_K    = 13'h0100,
    OS_R    = 13'h0200,
    OS_A    = 13'h0400,
    OS_CC   = 13'h0800,
    OS_SNF  = 13'h1000
  } ordered_sets_t;

  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_2 = 8'h5C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_6 = 8'hDC;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;
  localparam logic [7:0] D10_2 = 8'h4A;
  localparam logic [7:0] D12_1 = 8'h2C;
  localparam logic [7:0] D8_7  = 8'hE8;

  typedef struct packed {
    logic [2:0]      len;
    logic [3:0]      is_k;
    logic [3:0][7:0] chr;
  } ordered_seq_t;

  localparam ordered_seq_t SEQ_NONE = '{len: 3'd0, is_k: 4'b0000, chr: '0};
  localparam ordered_seq_t SEQ_SP   = '{len: 3'd4, is_k: 4'b0001, chr: {D10_2, D10_2, D10_2, K28_5}};
  localparam ordered_seq_t SEQ_SPA  = '{len: 3'd4, is_k: 4'b0001, chr: {D12_1, D12_1, D12_1, K28_5}};
  localparam ordered_seq_t SEQ_VER  = '{len: 3'd4, is_k: 4'b0001, chr: {D8_7, D8_7, D8_7, K28_5}};
  localparam ordered_seq_t SEQ_SCP  = '{len: 3'd2, is_k: 4'b0011, chr: {8'h00, 8'h00, K27_7, K28_2}};
  localparam ordered_seq_t SEQ_ECP  = '{len: 3'd2, is_k: 4'b0011, chr: {8'h00, 8'h00, K30_7, K29_7}};
  localparam ordered_seq_t SEQ_CC   = '{len: 3'd2, is_k: 4'b0011, chr: {8'h00, 8'h00, K23_7, K23_7}};
  localparam ordered_seq_t SEQ_P    = '{len: 3'd1, is_k: 4'b0001, chr: {24'h0, K28_4}};
  localparam ordered_seq_t SEQ_K    = '{len: 3'd1, is_k: 4'b0001, chr: {24'h0, K28_5}};
  localparam ordered_seq_t SEQ_R    = '{len: 3'd1, is_k: 4'b0001, chr: {24'h0, K28_0}};
  localparam ordered_seq_t SEQ_A    = '{len: 3'd1, is_k: 4'b0001, chr: {24'h0, K28_3}};
  localparam ordered_seq_t SEQ_SNF  = '{len: 3'd1, is_k: 4'b0001, chr: {24'h0, K28_6}};

  function automatic ordered_seq_t os_lookup(input ordered_sets_t os);
    case (os)
      OS_SP:          return SEQ_SP;
      OS_SPA:         return SEQ_SPA;
      OS_VER:         return SEQ_VER;
      OS_SCP:         return SEQ_SCP;
      OS_ECP:         return SEQ_ECP;
      OS_CC:          return SEQ_CC;
      OS_P, OS_SUF:   return SEQ_P;
      OS_K:           return SEQ_K;
      OS_R:           return SEQ_R;
      OS_A:           return SEQ_A;
      OS_SNF:         return SEQ_SNF;
      default:        return SEQ_NONE;
    endcase
  endfunction

endpackage

// File: rtl/idle_char_gen.sv
// Pseudo-random idle character source (K28.5 / K28.0 / K28.3).
//   clk, rst_n : clock, asynchronous active-low reset
//   n_idle     : per-lane mask, 1 = this lane carries an idle char this cycle
//   idle_chr   : per-lane idle char, lane i = idle_chr[i*8 +: 8]
// The LFSR (x^7+x^6+1) advances once per cycle in which any lane is idle; the
// /A/ countdown is consumed lane by lane in ascending order.
module idle_char_gen
  import aurora_pkg::*;
#(
  parameter int unsigned LANES     = 2,
  parameter logic [6:0]  LFSR_SEED = 7'h7F,
  parameter int unsigned A_MIN     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LANES-1:0]   n_idle,
  output logic [LANES*8-1:0] idle_chr
);

  localparam int unsigned AW = $clog2(A_MIN + 16);

  logic [6:0]    lfsr;
  logic [AW-1:0] a_cnt;
  logic [AW-1:0] cnt_nxt;
  logic [AW-1:0] a_reload;
  logic          a_used;

  assign a_reload = AW'(A_MIN) + AW'(lfsr[3:0]);

  // The running count carries from one idle lane to the next within a cycle;
  // a_used caps /A/ at one per cycle even for a tiny A_MIN.
  always_comb begin
    cnt_nxt  = a_cnt;
    a_used   = 1'b0;
    idle_chr = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (n_idle[i]) begin
        if (cnt_nxt == '0 && !a_used) begin
          idle_chr[i*8 +: 8] = K28_3;
          cnt_nxt            = a_reload;
          a_used             = 1'b1;
        end else begin
          idle_chr[i*8 +: 8] = lfsr[i] ? K28_5 : K28_0;
          if (cnt_nxt != '0) cnt_nxt = cnt_nxt - AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr  <= LFSR_SEED;
      a_cnt <= AW'(A_MIN);
    end else if (|n_idle) begin
      lfsr  <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      a_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/ordered_sets_lane_encoder.sv
// Multi-lane ordered-set encoder feeding the Aurora 8b/10b TX path.
//   clk, rst_n  : clock, asynchronous active-low reset
//   os_valid    : request valid; os_code one-hot ordered_sets_t
//   os_ready    : request accepted on os_valid & os_ready (depends on state only)
//   tx_data     : LANES chars, lane 0 = tx_data[CHAR_W-1:0], transmitted first
//   tx_is_k     : per-lane K flag
//   tx_idle     : per-lane flag, char came from the idle generator
//   err_illegal : one-cycle pulse when an accepted code is not one-hot
// LANES must not exceed MAX_SEQ_LEN.
module ordered_sets_lane_encoder
  import aurora_pkg::*;
#(
  parameter int unsigned LANES       = 2,
  parameter int unsigned MAX_SEQ_LEN = 4,
  parameter int unsigned CHAR_W      = 8,
  parameter logic [6:0]  LFSR_SEED   = 7'h7F,
  parameter int unsigned A_MIN       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    os_valid,
  input  logic [12:0]             os_code,
  output logic                    os_ready,
  output logic [LANES*CHAR_W-1:0] tx_data,
  output logic [LANES-1:0]        tx_is_k,
  output logic [LANES-1:0]        tx_idle,
  output logic                    err_illegal
);

  localparam int unsigned RW = $clog2(MAX_SEQ_LEN + 1);
  localparam int unsigned BW = MAX_SEQ_LEN * 8;

  // Buffer is kept left-aligned: slot 0 is always the next char to send, so
  // lane i simply reads slot i and the buffer shifts down by what was taken.
  logic [BW-1:0]          buf_chr;
  logic [MAX_SEQ_LEN-1:0] buf_k;
  logic [RW-1:0]          rem;

  int unsigned            take_u;
  logic [LANES-1:0]       idle_mask;
  logic [LANES*8-1:0]     idle_chr;
  logic [LANES*8-1:0]     lane_chr;
  logic [LANES-1:0]       lane_k;
  logic                   accept;
  logic                   legal;
  ordered_seq_t           seq;

  assign os_ready = (32'(rem) <= LANES);
  assign accept   = os_valid && os_ready;
  assign legal    = $onehot(os_code);
  assign seq      = os_lookup(ordered_sets_t'(os_code));

  always_comb begin
    take_u    = (32'(rem) > LANES) ? LANES : 32'(rem);
    idle_mask = '0;
    for (int unsigned i = 0; i < LANES; i++) idle_mask[i] = (i >= take_u);
  end

  idle_char_gen #(
    .LANES    (LANES),
    .LFSR_SEED(LFSR_SEED),
    .A_MIN    (A_MIN)
  ) u_idle (
    .clk     (clk),
    .rst_n   (rst_n),
    .n_idle  (idle_mask),
    .idle_chr(idle_chr)
  );

  always_comb begin
    lane_chr = '0;
    lane_k   = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_chr[i*8 +: 8] = idle_mask[i] ? idle_chr[i*8 +: 8] : buf_chr[i*8 +: 8];
      lane_k[i]          = idle_mask[i] ? 1'b1 : buf_k[i];
    end
  end

  // A request is only accepted when the current tail fits in this beat, so
  // loading the new set over the buffer loses nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_chr     <= '0;
      buf_k       <= '0;
      rem         <= '0;
      tx_data     <= '0;
      tx_is_k     <= '0;
      tx_idle     <= '0;
      err_illegal <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < LANES; i++)
        tx_data[i*CHAR_W +: CHAR_W] <= CHAR_W'(lane_chr[i*8 +: 8]);
      tx_is_k     <= lane_k;
      tx_idle     <= idle_mask;
      err_illegal <= accept && !legal;
      if (accept) begin
        if (legal) begin
          buf_chr <= BW'(seq.chr);
          buf_k   <= MAX_SEQ_LEN'(seq.is_k);
          rem     <= RW'(seq.len);
        end else begin
          rem     <= '0;
        end
      end else begin
        buf_chr <= buf_chr >> (take_u * 8);
        buf_k   <= buf_k >> take_u;
        rem     <= rem - RW'(take_u);
      end
    end
  end

endmodule
